breakout_physics: RTL and testbench
===================================

# breakout_physics

Per-frame game-state engine for the breakout display. Once per video frame it moves the paddle and the ball, resolves wall, brick and paddle collisions, and maintains brick-alive flags and game-over/win status. Its registered outputs (ball position, paddle centre, brick mask, status) feed the pixel-colouring display stage directly downstream, which only compares them against the scan position.

## Interface
Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball square edge in pixels
- BALL_SPEED, 2, ball step per frame on each axis
- PADDLE_HALF, 40, paddle half-width
- PADDLE_SPEED, 4, paddle step per frame
- PADDLE_Y_MIN, 450, paddle top row; PADDLE_Y_MAX, 470, paddle bottom row
- ROW_MIN, 60, brick row top; ROW_MAX, 100, brick row bottom; BRICK_W, 128, brick width (5 bricks)

Ports:
- CLOCK_50  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- frameTick  in  1  one-cycle pulse once per frame (start of vertical blank)
- start  in  1  one-cycle pulse: launch ball / restart after game end
- moveLeft, moveRight  in  1 each  paddle button levels, already synchronised
- ballX, ballY  out  11 each  top-left corner of the ball
- paddleX  out  11  paddle centre column
- brickOn  out  5  bit i = 1: brick i alive
- gameOver  out  1  ball reached bottom edge
- win  out  1  all bricks cleared
- busy  out  1  frame update in progress

## Operation
- States: IDLE (ball parked on paddle), WAIT (playing, awaiting tick), PADDLE, BALL, COLLIDE, OVER.
- Reset values: ballX=316, ballY=442, paddleX=320, brickOn=5'b11111, gameOver=0, win=0, busy=0, dirX=right, dirY=up, state IDLE.
- Paddle step (PADDLE state, also on each tick in IDLE): moveLeft only -> paddleX-=PADDLE_SPEED, floor PADDLE_HALF (40); moveRight only -> +=, ceiling SCREEN_W-PADDLE_HALF (600); both or neither -> unchanged.
- IDLE: on each tick, paddle steps and ball follows: ballX=paddleX-BALL_SIZE/2, ballY=PADDLE_Y_MIN-BALL_SIZE. start -> WAIT with dirX right, dirY up.
- BALL: next position = current ± BALL_SPEED per direction bit; computed in 12-bit signed, clamped to 0..SCREEN_W-BALL_SIZE horizontally and >=0 vertically.
- COLLIDE, all evaluated on the new position, applied in one cycle:
  - ballX==0 or ballX+BALL_SIZE>=SCREEN_W -> flip dirX. ballY==0 -> flip dirY. Corner hit flips both.
  - Brick: ball rect overlaps ROW_MIN..ROW_MAX and brickOn[idx]=1, idx = (ballX+BALL_SIZE/2)/BRICK_W clamped to 4 -> clear brickOn[idx], flip dirY. At most one brick per frame.
  - Paddle: dirY down, ballY+BALL_SIZE>=PADDLE_Y_MIN, ballY<=PADDLE_Y_MAX, centre within paddleX±PADDLE_HALF inclusive -> dirY up, ballY=PADDLE_Y_MIN-BALL_SIZE.
  - Else ballY+BALL_SIZE>=SCREEN_H -> gameOver=1, ->OVER.
  - brickOn becomes 0 -> win=1, ->OVER (win takes priority over gameOver in the same frame).
- OVER: outputs frozen, ticks ignored; start -> all reset values, IDLE.
- Brick and paddle hit in one frame is geometrically impossible; no arbitration required.

## Timing
- frameTick sampled in WAIT/IDLE at edge T; PADDLE at T+1, BALL at T+2, COLLIDE at T+3; all outputs final after edge T+3; busy=1 from T+1 through T+3.
- frameTick while busy or in OVER: dropped, not queued.
- start has priority over a coincident frameTick in IDLE/OVER; tick discarded that cycle.
- All outputs registered; no combinational input-to-output path.
- Reset assertion mid-update aborts immediately to reset values, regardless of state.

## Structure
- breakout_pkg: screen, ball, paddle, brick geometry constants and the state enum; shared with the display stage so geometry is defined once.
- One sub-module brick_hit_detect: combinational overlap test and brick index from ball position plus brickOn; returns hit and one-hot clear mask.

## Test plan
- Reset released, no input -> ballX=316, ballY=442, paddleX=320, brickOn=11111, busy=0 on every tick.
- IDLE, moveLeft held for 80 ticks -> paddleX steps 4/frame and saturates at 40; ballX tracks at 36.
- start, ticks: ball climbs 2/frame; ball centre at x=200 reaches y<=100 -> brickOn=11101, dirY down next frame.
- Ball moving right reaches ballX=632 -> next frame ballX decreases by 2; corner (0,0) -> both directions flip.
- Paddle moved away, ball falls -> gameOver=1 when ballY+8>=480; further ticks change nothing; start -> reset values.
- frameTick pulses at T and T+2 -> second pulse ignored, exactly one update; reset pulsed at T+2 -> outputs at reset values.

Source files
------------

// File: rtl/breakout_pkg.sv
// Breakout geometry and physics-engine state encoding, shared with the display stage
// so screen, ball, paddle and brick dimensions are defined in exactly one place.
package breakout_pkg;
  localparam int GEOM_SCREEN_W     = 640;
  localparam int GEOM_SCREEN_H     = 480;
  localparam int GEOM_BALL_SIZE    = 8;
  localparam int GEOM_BALL_SPEED   = 2;
  localparam int GEOM_PADDLE_HALF  = 40;
  localparam int GEOM_PADDLE_SPEED = 4;
  localparam int GEOM_PADDLE_Y_MIN = 450;
  localparam int GEOM_PADDLE_Y_MAX = 470;
  localparam int GEOM_ROW_MIN      = 60;
  localparam int GEOM_ROW_MAX      = 100;
  localparam int GEOM_BRICK_W      = 128;
  localparam int GEOM_BRICK_N      = 5;
  localparam int POS_W             = 11;
  localparam int IDX_W             = $clog2(GEOM_BRICK_N);

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [IDX_W-1:0] idx_t;

  // state      | meaning
  // ST_IDLE    | ball parked on paddle, paddle steps on each tick
  // ST_WAIT    | playing, waiting for the next frame tick
  // ST_PADDLE  | paddle step
  // ST_BALL    | ball step with screen clamp
  // ST_COLLIDE | walls, bricks, paddle, end-of-game resolution
  // ST_OVER    | outputs frozen until start
  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_PADDLE, ST_BALL, ST_COLLIDE, ST_OVER
  } state_t;

  function automatic pos_t paddle_step(input pos_t px, input logic left, input logic right,
                                       input pos_t lo, input pos_t hi, input pos_t step);
    pos_t res;
    res = px;
    if (left && !right)
      res = (px >= lo + step) ? px - step : lo;
    else if (right && !left)
      res = (px + step <= hi) ? px + step : hi;
    return res;
  endfunction
endpackage

// File: rtl/breakout_physics_if.sv
// Control inputs and registered game-state outputs of the breakout physics engine.
interface breakout_physics_if;
  import breakout_pkg::*;

  logic                    frameTick;
  logic                    start;
  logic                    moveLeft;
  logic                    moveRight;
  logic [POS_W-1:0]        ballX;
  logic [POS_W-1:0]        ballY;
  logic [POS_W-1:0]        paddleX;
  logic [GEOM_BRICK_N-1:0] brickOn;
  logic                    gameOver;
  logic                    win;
  logic                    busy;

  modport master (
    output frameTick, start, moveLeft, moveRight,
    input  ballX, ballY, paddleX, brickOn, gameOver, win, busy
  );

  modport slave (
    input  frameTick, start, moveLeft, moveRight,
    output ballX, ballY, paddleX, brickOn, gameOver, win, busy
  );
endinterface

// File: rtl/brick_hit_detect.sv
// Combinational brick-row overlap test; selects the brick under the ball centre
// and returns a hit flag plus a one-hot mask of the brick to clear.
module brick_hit_detect
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE = GEOM_BALL_SIZE,
  parameter int ROW_MIN   = GEOM_ROW_MIN,
  parameter int ROW_MAX   = GEOM_ROW_MAX,
  parameter int BRICK_W   = GEOM_BRICK_W
) (
  input  pos_t                    ball_x,
  input  pos_t                    ball_y,
  input  logic [GEOM_BRICK_N-1:0] bricks,
  output logic                    hit,
  output logic [GEOM_BRICK_N-1:0] clr
);
  // Ball rows ball_y..ball_y+BALL_SIZE-1 touch the row band once ball_y passes this
  localparam pos_t TOP_REACH = pos_t'(ROW_MIN - BALL_SIZE);
  localparam pos_t ROW_LAST  = pos_t'(ROW_MAX);
  localparam pos_t LAST_COL  = pos_t'(GEOM_BRICK_N - 1);

  pos_t centre;
  pos_t col;
  idx_t idx;
  logic in_row;

  always_comb begin
    centre = ball_x + pos_t'(BALL_SIZE / 2);
    col    = centre / pos_t'(BRICK_W);
    idx    = (col >= LAST_COL) ? idx_t'(GEOM_BRICK_N - 1) : col[IDX_W-1:0];
    in_row = (ball_y <= ROW_LAST) && (ball_y > TOP_REACH);
    hit    = in_row && bricks[idx];
    clr    = '0;
    if (hit)
      clr[idx] = 1'b1;
  end
endmodule

// File: rtl/breakout_physics.sv
// Per-frame breakout game-state engine: paddle and ball motion, wall/brick/paddle
// collisions, brick flags and end-of-game status, all updated once per frame tick.
module breakout_physics
  import breakout_pkg::*;
#(
  parameter int SCREEN_W     = GEOM_SCREEN_W,
  parameter int SCREEN_H     = GEOM_SCREEN_H,
  parameter int BALL_SIZE    = GEOM_BALL_SIZE,
  parameter int BALL_SPEED   = GEOM_BALL_SPEED,
  parameter int PADDLE_HALF  = GEOM_PADDLE_HALF,
  parameter int PADDLE_SPEED = GEOM_PADDLE_SPEED,
  parameter int PADDLE_Y_MIN = GEOM_PADDLE_Y_MIN,
  parameter int PADDLE_Y_MAX = GEOM_PADDLE_Y_MAX,
  parameter int ROW_MIN      = GEOM_ROW_MIN,
  parameter int ROW_MAX      = GEOM_ROW_MAX,
  parameter int BRICK_W      = GEOM_BRICK_W
) (
  input logic               CLOCK_50,
  input logic               reset,
  breakout_physics_if.slave bus
);
  localparam pos_t X_MAX     = pos_t'(SCREEN_W - BALL_SIZE);
  localparam pos_t Y_BOTTOM  = pos_t'(SCREEN_H - BALL_SIZE);
  localparam pos_t Y_REST    = pos_t'(PADDLE_Y_MIN - BALL_SIZE);
  localparam pos_t X_HOME    = pos_t'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam pos_t P_HOME    = pos_t'(SCREEN_W / 2);
  localparam pos_t P_LO      = pos_t'(PADDLE_HALF);
  localparam pos_t P_HI      = pos_t'(SCREEN_W - PADDLE_HALF);
  localparam pos_t P_STEP    = pos_t'(PADDLE_SPEED);
  localparam pos_t P_HALF    = pos_t'(PADDLE_HALF);
  localparam pos_t P_Y_MAX   = pos_t'(PADDLE_Y_MAX);
  localparam pos_t HALF_BALL = pos_t'(BALL_SIZE / 2);
  localparam logic signed [11:0] SPD     = 12'(BALL_SPEED);
  localparam logic signed [11:0] X_MAX_S = 12'(SCREEN_W - BALL_SIZE);

  state_t                  state, state_nx;
  pos_t                    ball_x, ball_y, paddle_x;
  pos_t                    ball_x_nx, ball_y_nx, paddle_x_nx;
  pos_t                    px_step, x_moved, y_moved, centre;
  logic [GEOM_BRICK_N-1:0] bricks, bricks_nx, clr;
  logic                    game_over, game_over_nx, win_q, win_nx, busy_q, busy_nx;
  logic                    dir_x, dir_x_nx, dir_y, dir_y_nx;
  logic                    hit, wall_x, wall_y, paddle_hit, bottom;
  logic signed [11:0]      sx, sy;

  brick_hit_detect #(
    .BALL_SIZE (BALL_SIZE),
    .ROW_MIN   (ROW_MIN),
    .ROW_MAX   (ROW_MAX),
    .BRICK_W   (BRICK_W)
  ) u_brick_hit (
    .ball_x (ball_x),
    .ball_y (ball_y),
    .bricks (bricks),
    .hit    (hit),
    .clr    (clr)
  );

  assign px_step = paddle_step(paddle_x, bus.moveLeft, bus.moveRight, P_LO, P_HI, P_STEP);

  // dir_x = 1 moves right, dir_y = 1 moves up; the step is signed so the clamp sees underflow
  always_comb begin
    sx = $signed({1'b0, ball_x}) + (dir_x ? SPD : -SPD);
    sy = $signed({1'b0, ball_y}) + (dir_y ? -SPD : SPD);
    if (sx < 12'sd0)
      x_moved = '0;
    else if (sx > X_MAX_S)
      x_moved = X_MAX;
    else
      x_moved = sx[POS_W-1:0];
    if (sy < 12'sd0)
      y_moved = '0;
    else
      y_moved = sy[POS_W-1:0];
  end

  always_comb begin
    centre     = ball_x + HALF_BALL;
    wall_x     = (ball_x == '0) || (ball_x >= X_MAX);
    wall_y     = (ball_y == '0);
    bottom     = (ball_y >= Y_BOTTOM);
    paddle_hit = !dir_y && (ball_y >= Y_REST) && (ball_y <= P_Y_MAX) &&
                 (centre >= paddle_x - P_HALF) && (centre <= paddle_x + P_HALF);
  end

  always_comb begin
    state_nx     = state;
    ball_x_nx    = ball_x;
    ball_y_nx    = ball_y;
    paddle_x_nx  = paddle_x;
    bricks_nx    = bricks;
    dir_x_nx     = dir_x;
    dir_y_nx     = dir_y;
    game_over_nx = game_over;
    win_nx       = win_q;
    busy_nx      = busy_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_WAIT;
          dir_x_nx = 1'b1;
          dir_y_nx = 1'b1;
        end else if (bus.frameTick) begin
          paddle_x_nx = px_step;
          ball_x_nx   = px_step - HALF_BALL;
          ball_y_nx   = Y_REST;
        end
      end
      ST_WAIT: begin
        if (bus.frameTick) begin
          state_nx = ST_PADDLE;
          busy_nx  = 1'b1;
        end
      end
      ST_PADDLE: begin
        paddle_x_nx = px_step;
        state_nx    = ST_BALL;
      end
      ST_BALL: begin
        ball_x_nx = x_moved;
        ball_y_nx = y_moved;
        state_nx  = ST_COLLIDE;
      end
      ST_COLLIDE: begin
        busy_nx   = 1'b0;
        state_nx  = ST_WAIT;
        dir_x_nx  = dir_x ^ wall_x;
        dir_y_nx  = dir_y ^ wall_y ^ hit;
        bricks_nx = bricks & ~clr;
        if (paddle_hit) begin
          dir_y_nx  = 1'b1;
          ball_y_nx = Y_REST;
        end
        if (bricks_nx == '0) begin
          win_nx   = 1'b1;
          state_nx = ST_OVER;
        end else if (bottom && !paddle_hit) begin
          game_over_nx = 1'b1;
          state_nx     = ST_OVER;
        end
      end
      ST_OVER: begin
        if (bus.start) begin
          state_nx     = ST_IDLE;
          ball_x_nx    = X_HOME;
          ball_y_nx    = Y_REST;
          paddle_x_nx  = P_HOME;
          bricks_nx    = '1;
          dir_x_nx     = 1'b1;
          dir_y_nx     = 1'b1;
          game_over_nx = 1'b0;
          win_nx       = 1'b0;
          busy_nx      = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ball_x    <= X_HOME;
      ball_y    <= Y_REST;
      paddle_x  <= P_HOME;
      bricks    <= '1;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      game_over <= 1'b0;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      ball_x    <= ball_x_nx;
      ball_y    <= ball_y_nx;
      paddle_x  <= paddle_x_nx;
      bricks    <= bricks_nx;
      dir_x     <= dir_x_nx;
      dir_y     <= dir_y_nx;
      game_over <= game_over_nx;
      win_q     <= win_nx;
      busy_q    <= busy_nx;
    end
  end

  assign bus.ballX    = ball_x;
  assign bus.ballY    = ball_y;
  assign bus.paddleX  = paddle_x;
  assign bus.brickOn  = bricks;
  assign bus.gameOver = game_over;
  assign bus.win      = win_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_breakout_physics.sv
// Bench for breakout_physics: frame-level game model compared every idle cycle,
// plus hand-computed positions at reset, paddle saturation, brick hit, wall and game over.
module tb_breakout_physics;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  breakout_physics_if bus();
  breakout_physics dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  bit armed    = 0;
  bit pending  = 1;

  // model: mode 0 parked, 1 playing, 2 over; dx 1 = right, dy 1 = up
  int m_bx, m_by, m_px, m_mode;
  bit m_dx, m_dy, m_go, m_win;
  logic [4:0] m_br;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bx = 316; m_by = 442; m_px = 320; m_br = 5'b11111;
    m_go = 0; m_win = 0; m_mode = 0; m_dx = 1; m_dy = 1;
  endfunction

  function automatic void model_start();
    if (m_mode == 0) begin
      m_mode = 1; m_dx = 1; m_dy = 1;
    end else if (m_mode == 2) begin
      model_reset();
    end
  endfunction

  function automatic void model_tick(input bit l, input bit r);
    int nx, ny, c, idx;
    bit falling, bottom;
    if (m_mode == 2) return;
    if (l && !r) m_px = (m_px - 4 < 40) ? 40 : m_px - 4;
    else if (r && !l) m_px = (m_px + 4 > 600) ? 600 : m_px + 4;
    if (m_mode == 0) begin
      m_bx = m_px - 4; m_by = 442;
      return;
    end
    falling = !m_dy;
    nx = m_bx + (m_dx ? 2 : -2);
    if (nx < 0) nx = 0;
    if (nx > 632) nx = 632;
    ny = m_by + (m_dy ? -2 : 2);
    if (ny < 0) ny = 0;
    m_bx = nx; m_by = ny;
    if (nx == 0 || nx + 8 >= 640) m_dx = !m_dx;
    if (ny == 0) m_dy = !m_dy;
    c = nx + 4;
    idx = c / 128;
    if (idx > 4) idx = 4;
    if (ny <= 100 && ny + 7 >= 60 && m_br[idx]) begin
      m_br[idx] = 1'b0;
      m_dy = !m_dy;
    end
    bottom = 0;
    if (falling && ny + 8 >= 450 && ny <= 470 && c >= m_px - 40 && c <= m_px + 40) begin
      m_dy = 1; m_by = 442;
    end else begin
      bottom = (ny + 8 >= 480);
    end
    if (m_br == 5'b0) begin
      m_win = 1; m_mode = 2;
    end else if (bottom) begin
      m_go = 1; m_mode = 2;
    end
  endfunction

  always @(negedge clk) begin
    if (armed && !pending) begin
      chk("ballX", int'(bus.ballX), m_bx);
      chk("ballY", int'(bus.ballY), m_by);
      chk("paddleX", int'(bus.paddleX), m_px);
      chk("brickOn", int'(bus.brickOn), int'(m_br));
      chk("gameOver", int'(bus.gameOver), int'(m_go));
      chk("win", int'(bus.win), int'(m_win));
      chk("busy_idle", int'(bus.busy), 0);
    end
  end

  task automatic tick(input bit l, input bit r, input bit dbl);
    int play;
    play = (m_mode == 1) ? 1 : 0;
    pending = 1;
    @(negedge clk);
    bus.frameTick = 1; bus.moveLeft = l; bus.moveRight = r;
    @(negedge clk);
    bus.frameTick = 0;
    chk("busy_t1", int'(bus.busy), play);
    @(negedge clk);
    if (dbl) bus.frameTick = 1;
    chk("busy_t2", int'(bus.busy), play);
    @(negedge clk);
    bus.frameTick = 0;
    chk("busy_t3", int'(bus.busy), play);
    @(negedge clk);
    model_tick(l, r);
    pending = 0;
  endtask

  task automatic press_start(input bit with_tick, input bit l, input bit r);
    pending = 1;
    @(negedge clk);
    bus.start = 1; bus.frameTick = with_tick; bus.moveLeft = l; bus.moveRight = r;
    @(negedge clk);
    bus.start = 0; bus.frameTick = 0;
    model_start();
    pending = 0;
  endtask

  task automatic reset_mid();
    pending = 1;
    @(negedge clk);
    bus.frameTick = 1; bus.moveLeft = 0; bus.moveRight = 0;
    @(negedge clk);
    bus.frameTick = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rm_ballX", int'(bus.ballX), 316);
    chk("rm_ballY", int'(bus.ballY), 442);
    chk("rm_paddleX", int'(bus.paddleX), 320);
    chk("rm_brickOn", int'(bus.brickOn), 31);
    chk("rm_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1;
    model_reset();
    pending = 0;
  endtask

  initial begin
    bit l, r;
    bus.frameTick = 0; bus.start = 0; bus.moveLeft = 0; bus.moveRight = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ballX", int'(bus.ballX), 316);
    chk("rst_ballY", int'(bus.ballY), 442);
    chk("rst_paddleX", int'(bus.paddleX), 320);
    chk("rst_brickOn", int'(bus.brickOn), 31);
    chk("rst_busy", int'(bus.busy), 0);
    rst = 1;
    armed = 1;
    pending = 0;

    repeat (3) tick(0, 0, 0);
    chk("idle_ballX", int'(bus.ballX), 316);

    repeat (80) tick(1, 0, 0);
    chk("sat_paddleX", int'(bus.paddleX), 40);
    chk("sat_ballX", int'(bus.ballX), 36);

    // start with a coincident tick and moveRight held: tick must be discarded
    press_start(1, 0, 1);
    chk("start_prio_paddleX", int'(bus.paddleX), 40);

    repeat (171) tick(0, 0, 0);
    chk("brick_brickOn", int'(bus.brickOn), 5'b11011);
    chk("brick_ballY", int'(bus.ballY), 100);
    chk("brick_ballX", int'(bus.ballX), 378);
    tick(0, 0, 0);
    chk("after_brick_ballY", int'(bus.ballY), 102);

    // right wall at x=632 after 127 frames, then falls to y=472 at x=514
    repeat (185) tick(0, 0, 0);
    chk("over_gameOver", int'(bus.gameOver), 1);
    chk("over_ballY", int'(bus.ballY), 472);
    chk("over_ballX", int'(bus.ballX), 514);
    chk("over_win", int'(bus.win), 0);

    repeat (3) tick(0, 1, 0);
    chk("frozen_paddleX", int'(bus.paddleX), 40);

    press_start(0, 0, 0);
    chk("restart_ballX", int'(bus.ballX), 316);
    chk("restart_brickOn", int'(bus.brickOn), 31);
    chk("restart_gameOver", int'(bus.gameOver), 0);

    press_start(0, 0, 0);
    tick(0, 0, 1);
    chk("dbl_ballY", int'(bus.ballY), 440);
    chk("dbl_ballX", int'(bus.ballX), 318);
    tick(0, 0, 1);
    chk("dbl2_ballY", int'(bus.ballY), 438);

    reset_mid();

    // long rally: paddle chases the ball, sometimes with both buttons pressed
    press_start(0, 0, 0);
    for (int f = 0; f < 3000 && m_mode == 1; f++) begin
      l = 0; r = 0;
      if (f % 11 == 5) begin
        l = 1; r = 1;
      end else if (m_px < m_bx + 4 - 6) begin
        r = 1;
      end else if (m_px > m_bx + 4 + 6) begin
        l = 1;
      end
      tick(l, r, 0);
    end
    repeat (2) tick(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
